nor_block_lock_writer: RTL and testbench
========================================

// Module: nor_block_lock_writer
// PURPOSE
// Sets or clears the lock bit of one NOR flash block, then reads the lock status back to confirm it.
// The block is the write-side companion of the lock-status reader. It owns the flash bus (ADDR/DATA/CE/WE/OE) while BUSY is high.
// It issues: setup 0x0060, confirm (0x0001 lock / 0x00D0 unlock), read-ID 0x0090, status read at block+2, then read-array 0x00FF.
// PARAMETERS
// T_WP   6   clock cycles WE is held low per write cycle (60 ns at 100 MHz)
// T_WPH  3   clock cycles of recovery with CE/WE/OE high after every bus cycle
// T_ACC  11  clock cycles CE/OE are held low before read data is sampled (110 ns)
// PORTS
// CLK       in    1   system clock, all logic on rising edge
// RST_N     in    1   reset, synchronous, active-low
// START     in    1   one-cycle request; sampled only in IDLE
// LOCK      in    1   1 = lock block (confirm 0x0001), 0 = unlock (confirm 0x00D0)
// BLK_ADDR  in    24  block base address; latched on accepted START
// BUSY      out   1   high from the accepted START until DONE
// DONE      out   1   one-cycle pulse when the sequence completes
// PASS      out   1   read-back DATA[0] equals latched LOCK; valid from DONE until next START
// STATUS    out   8   read-back DATA[7:0]; valid from DONE until next START
// ADDR      out   24  flash address
// DATA      inout 16  flash data; driven only during write cycles, else high-Z
// CE        out   1   flash chip enable, active-low
// WE        out   1   flash write enable, active-low
// OE        out   1   flash output enable, active-low
// BEHAVIOUR
// - Reset (RST_N=0 at an edge): CE=WE=OE=1, DATA high-Z, ADDR=0, BUSY=DONE=PASS=0, STATUS=0, FSM=IDLE.
// - Reset mid-sequence aborts at that edge: bus idle next cycle, no DONE.
// - FSM: IDLE -> WR_LOW -> WR_REC -> (next step) ... -> RD_LOW -> RD_REC -> WR_LOW(0xFF) -> WR_REC -> FIN -> IDLE.
// - Step counter 0..4 selects the step: 0 = 0x0060@BLK, 1 = confirm@BLK, 2 = 0x0090@BLK, 3 = read@BLK+2, 4 = 0x00FF@BLK.
// - IDLE: on START=1 at edge N, latch BLK_ADDR and LOCK; set BUSY=1, ADDR=BLK, DATA=0x0060, CE=0, WE=0.
// - IDLE: START while BUSY is ignored (no re-latch, no restart).
// - WR_LOW: CE=0, WE=0, OE=1, DATA driven, held for T_WP cycles.
// - WR_REC: CE=WE=OE=1; DATA stays driven through the recovery cycles (hold time); held T_WPH cycles.
// - ADDR and DATA are stable for the whole bus cycle. They change only on entry to the next WR_LOW/RD_LOW.
// - RD_LOW: DATA released (high-Z) on entry, ADDR=(BLK+2) mod 2^24, CE=0, OE=0, WE=1, held T_ACC cycles.
// - RD_LOW: DATA sampled on the last edge of RD_LOW into STATUS=DATA[7:0] and PASS=(DATA[0]==LOCK).
// - RD_REC: CE=OE=1 for T_WPH cycles, then step 4.
// - FIN: DONE=1 for one cycle and BUSY=0 in the same cycle; return to IDLE.
// - Timing: DONE is high in the cycle after edge N+4*(T_WP+T_WPH)+T_ACC+T_WPH (N+50 with defaults).
// - A new START may be accepted in the cycle after DONE.
// - CE, WE and OE are never low together. WE and OE are never both low.
// - Address arithmetic is 24-bit modulo: BLK_ADDR=0xFFFFFE reads at 0x000000.
// - PASS/STATUS are cleared to 0 on an accepted START.
// TESTING
// - Unlock: LOCK=0, BLK_ADDR=0x020000, model returns 0x0000 on read.
//   -> writes 0x0060, 0x00D0, 0x0090 @020000; read @020002; write 0x00FF; PASS=1, STATUS=0x00, DONE at N+50.
// - Lock: LOCK=1, BLK_ADDR=0x040000, model returns 0x0001.
//   -> confirm data 0x0001; PASS=1, STATUS=0x01; WE low exactly 6 cycles per write.
// - Mismatch: LOCK=1, model returns 0x0000 -> PASS=0, STATUS=0x00; DONE still pulses once.
// - START pulsed at N+10 during a busy sequence -> ignored; exactly 5 bus cycles, one DONE.
// - RST_N=0 during RD_LOW -> next cycle CE=WE=OE=1, DATA high-Z, BUSY=0; no DONE. A new START then runs normally.
// - BLK_ADDR=0xFFFFFE -> command cycles at 0xFFFFFE, read cycle at 0x000000.
// - Bus checker throughout: DATA high-Z whenever OE=0; never CE=WE=OE=0 together.

Source files
------------

// File: rtl/nor_block_lock_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nor_block_lock_writer
// Description : Sets or clears the lock bit of one NOR flash block
//               (0x60 setup, 0x01/0xD0 confirm), issues read-ID 0x90, reads
//               the lock status at block+2 and returns to read-array 0xFF.
//               Reports the read-back status and a pass flag.
// Revision    : 1.0 - initial release
// ============================================================================
module nor_block_lock_writer #(
    parameter int T_WP  = 6,
    parameter int T_WPH = 3,
    parameter int T_ACC = 11
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_lock,
    input  logic [23:0] i_blk_addr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [7:0]  o_status,
    output logic [23:0] o_addr,
    inout  wire  [15:0] io_data,
    output logic        o_ce,
    output logic        o_we,
    output logic        o_oe
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_LOW = 3'd1,
        S_WR_REC = 3'd2,
        S_RD_LOW = 3'd3,
        S_RD_REC = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    localparam logic [7:0] c_WP_LAST  = 8'(T_WP - 1);
    localparam logic [7:0] c_WPH_LAST = 8'(T_WPH - 1);
    localparam logic [7:0] c_ACC_LAST = 8'(T_ACC - 1);

    state_t      r_state,  w_state_nxt;
    logic [7:0]  r_cnt,    w_cnt_nxt;
    logic [2:0]  r_step,   w_step_nxt;
    logic        r_lock,   w_lock_nxt;
    logic [23:0] r_blk,    w_blk_nxt;
    logic [23:0] r_addr,   w_addr_nxt;
    logic [15:0] r_data,   w_data_nxt;
    logic        r_pass,   w_pass_nxt;
    logic [7:0]  r_status, w_status_nxt;
    logic        w_drive;
    logic        w_unused_hi;

    // Upper data byte carries nothing useful in the status word
    assign w_unused_hi = ^io_data[15:8];

    // Bus strobes decode directly from the registered state so they never
    // overlap: WE only in WR_LOW, OE only in RD_LOW.
    assign o_ce     = !((r_state == S_WR_LOW) || (r_state == S_RD_LOW));
    assign o_we     = (r_state != S_WR_LOW);
    assign o_oe     = (r_state != S_RD_LOW);
    assign w_drive  = (r_state == S_WR_LOW) || (r_state == S_WR_REC);
    assign io_data  = w_drive ? r_data : 16'hzzzz;
    assign o_addr   = r_addr;
    assign o_busy   = (r_state != S_IDLE) && (r_state != S_FIN);
    assign o_done   = (r_state == S_FIN);
    assign o_pass   = r_pass;
    assign o_status = r_status;

    // State, timers and latched operands; synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_step   <= 3'd0;
            r_lock   <= 1'b0;
            r_blk    <= 24'd0;
            r_addr   <= 24'd0;
            r_data   <= 16'd0;
            r_pass   <= 1'b0;
            r_status <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_step   <= w_step_nxt;
            r_lock   <= w_lock_nxt;
            r_blk    <= w_blk_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_pass   <= w_pass_nxt;
            r_status <= w_status_nxt;
        end
    end

    // Next-state: step sequencing, per-phase timers, address/data loading
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 8'd1;
        w_step_nxt   = r_step;
        w_lock_nxt   = r_lock;
        w_blk_nxt    = r_blk;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_pass_nxt   = r_pass;
        w_status_nxt = r_status;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 8'd0;
                if (i_start) begin
                    w_blk_nxt    = i_blk_addr;
                    w_lock_nxt   = i_lock;
                    w_addr_nxt   = i_blk_addr;
                    w_data_nxt   = 16'h0060;
                    w_step_nxt   = 3'd0;
                    w_pass_nxt   = 1'b0;
                    w_status_nxt = 8'd0;
                    w_state_nxt  = S_WR_LOW;
                end
            end
            S_WR_LOW: begin
                if (r_cnt == c_WP_LAST) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_WR_REC;
                end
            end
            S_WR_REC: begin
                if (r_cnt == c_WPH_LAST) begin
                    w_cnt_nxt = 8'd0;
                    case (r_step)
                        3'd0: begin
                            w_step_nxt  = 3'd1;
                            w_data_nxt  = r_lock ? 16'h0001 : 16'h00D0;
                            w_state_nxt = S_WR_LOW;
                        end
                        3'd1: begin
                            w_step_nxt  = 3'd2;
                            w_data_nxt  = 16'h0090;
                            w_state_nxt = S_WR_LOW;
                        end
                        3'd2: begin
                            w_step_nxt  = 3'd3;
                            w_addr_nxt  = r_blk + 24'd2;
                            w_state_nxt = S_RD_LOW;
                        end
                        default: w_state_nxt = S_FIN;
                    endcase
                end
            end
            S_RD_LOW: begin
                if (r_cnt == c_ACC_LAST) begin
                    w_cnt_nxt    = 8'd0;
                    w_status_nxt = io_data[7:0];
                    w_pass_nxt   = (io_data[0] == r_lock);
                    w_state_nxt  = S_RD_REC;
                end
            end
            S_RD_REC: begin
                if (r_cnt == c_WPH_LAST) begin
                    w_cnt_nxt   = 8'd0;
                    w_step_nxt  = 3'd4;
                    w_addr_nxt  = r_blk;
                    w_data_nxt  = 16'h00FF;
                    w_state_nxt = S_WR_LOW;
                end
            end
            S_FIN: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nor_block_lock_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nor_block_lock_writer
// Description : Self-checking bench for nor_block_lock_writer with a flash
//               read model, a bus-cycle monitor and a transaction-level
//               reference of the expected command sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nor_block_lock_writer;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic        i_lock;
    logic [23:0] i_blk_addr;
    logic        o_busy, o_done, o_pass;
    logic [7:0]  o_status;
    logic [23:0] o_addr;
    wire  [15:0] io_data;
    logic        o_ce, o_we, o_oe;

    logic [15:0] rd_val = 16'h0000;
    int          n_chk  = 0;
    int          n_err  = 0;

    always #5 clk = ~clk;

    nor_block_lock_writer dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_lock     (i_lock),
        .i_blk_addr (i_blk_addr),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_pass     (o_pass),
        .o_status   (o_status),
        .o_addr     (o_addr),
        .io_data    (io_data),
        .o_ce       (o_ce),
        .o_we       (o_we),
        .o_oe       (o_oe)
    );

    // Flash read model: drives the array value while CE and OE are low
    assign io_data = (!o_ce && !o_oe) ? rd_val : 16'hzzzz;

    typedef struct {
        bit          rd;
        logic [23:0] a;
        logic [15:0] d;
        int          len;
        bit          stable;
    } xact_t;

    xact_t mon_q[$];
    xact_t cur_w, cur_r;
    bit    w_on = 0, r_on = 0;
    int    done_cnt = 0;
    int    viol = 0;

    // Bus monitor: collects write/read bus cycles and flags illegal strobes
    always @(negedge clk) begin
        if (o_done) done_cnt++;
        if (!o_ce && !o_we && !o_oe) viol++;
        if (!o_we && !o_oe) viol++;
        if (!o_ce && !o_oe && io_data !== rd_val) viol++;
        if (!o_we) begin
            if (w_on) begin
                cur_w.len++;
                if (o_addr !== cur_w.a || io_data !== cur_w.d) cur_w.stable = 0;
            end else begin
                w_on  = 1;
                cur_w = '{0, o_addr, io_data, 1, 1};
            end
        end else if (w_on) begin
            mon_q.push_back(cur_w);
            w_on = 0;
        end
        if (!o_oe) begin
            if (r_on) begin
                cur_r.len++;
                if (o_addr !== cur_r.a) cur_r.stable = 0;
            end else begin
                r_on  = 1;
                cur_r = '{1, o_addr, io_data, 1, 1};
            end
        end else if (r_on) begin
            mon_q.push_back(cur_r);
            r_on = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One complete lock/unlock request checked against the command sequence
    task automatic run_seq(input logic lk, input logic [23:0] blk,
                           input logic [15:0] val, input bit poke);
        int          q0, d0, v0, lat;
        logic [23:0] ea[5];
        logic [15:0] ed[5];
        bit          er[5];
        int          el[5];
        ea = '{blk, blk, blk, blk + 24'd2, blk};
        ed = '{16'h0060, lk ? 16'h0001 : 16'h00D0, 16'h0090, val, 16'h00FF};
        er = '{0, 0, 0, 1, 0};
        el = '{6, 6, 6, 11, 6};
        rd_val = val;
        @(negedge clk);
        q0 = mon_q.size(); d0 = done_cnt; v0 = viol;
        i_lock = lk; i_blk_addr = blk; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("busy_after_start", o_busy, 1);
                check("pass_cleared", {o_pass, o_status}, 0);
            end
            if (poke && k == 9) begin
                i_start = 1'b1; i_lock = ~lk; i_blk_addr = blk + 24'h000100;
            end else if (poke && k == 10) begin
                i_start = 1'b0; i_lock = lk; i_blk_addr = blk;
            end
            if (o_done) begin
                lat = k;
                break;
            end
        end
        check("done_latency", lat, 50);
        check("busy_low_at_done", o_busy, 0);
        repeat (4) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("bus_cycles", mon_q.size() - q0, 5);
        for (int i = 0; i < 5 && (q0 + i) < mon_q.size(); i++) begin
            check($sformatf("cyc%0d_kind", i), mon_q[q0 + i].rd, er[i]);
            check($sformatf("cyc%0d_addr", i), mon_q[q0 + i].a, ea[i]);
            check($sformatf("cyc%0d_data", i), mon_q[q0 + i].d, ed[i]);
            check($sformatf("cyc%0d_len", i), mon_q[q0 + i].len, el[i]);
            check($sformatf("cyc%0d_stable", i), mon_q[q0 + i].stable, 1);
        end
        check("pass", o_pass, (val[0] == lk));
        check("status", o_status, val[7:0]);
        check("bus_rules", viol - v0, 0);
    endtask

    initial begin
        int d0, t;
        i_rst_n = 1'b0; i_start = 1'b0; i_lock = 1'b0; i_blk_addr = 24'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {o_ce, o_we, o_oe}, 3'b111);
        check("rst_flags", {o_busy, o_done, o_pass}, 3'b000);
        check("rst_status", o_status, 0);
        check("rst_addr", o_addr, 0);
        i_rst_n = 1'b1;

        run_seq(1'b0, 24'h020000, 16'h0000, 0);
        run_seq(1'b1, 24'h040000, 16'h0001, 0);
        run_seq(1'b1, 24'h040000, 16'h0000, 0);
        run_seq(1'b0, 24'hFFFFFE, 16'h12A4, 0);
        run_seq(1'b1, 24'h100000, 16'h00FF, 1);

        // Reset during the status read aborts the sequence
        rd_val = 16'h0001;
        @(negedge clk);
        i_lock = 1'b1; i_blk_addr = 24'h060000; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        t = 0;
        while (o_oe && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reached_read", o_oe, 0);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        i_rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobes", {o_ce, o_we, o_oe}, 3'b111);
        check("abort_busy", o_busy, 0);
        i_rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run_seq(1'b1, 24'h060000, 16'h0001, 0);

        for (int n = 0; n < 12; n++) begin
            logic        lk;
            logic [23:0] blk;
            logic [15:0] val;
            lk  = 1'($urandom);
            blk = 24'($urandom);
            if (n == 0) blk = 24'hFFFFFF;
            val = 16'($urandom);
            run_seq(lk, blk, val, 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
